// File: rtl/ram_copy_engine_pkg.sv
// rtl/ram_copy_engine_pkg.sv - shared widths and state encoding for the RAM copy/fill engine
package ram_copy_engine_pkg;

  localparam int DEF_ADDR_W = 15;
  localparam int DEF_LEN_W  = 16;
  localparam int BUS_W      = 32;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE   = 3'd1;
  localparam logic [2:0] ST_RD_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WR_ISSUE   = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_RD_ISSUE   = ST_RD_ISSUE,
    S_RD_CAPTURE = ST_RD_CAPTURE,
    S_WR_ISSUE   = ST_WR_ISSUE,
    S_DONE       = ST_DONE
  } state_t;

endpackage

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - word-granular block copy / fill bus initiator for the main RAM
module ram_copy_engine
  import ram_copy_engine_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_fill,
  input  logic              cfg_desc,
  input  logic [BUS_W-1:0]  cfg_value,
  input  logic [3:0]        cfg_bytesel,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BUS_W-1:0]  bus_wrdata,
  output logic [3:0]        bus_wrbytesel,
  output logic              bus_write,
  input  logic [BUS_W-1:0]  bus_rddata,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, addr_hold, step;
  logic [LEN_W-1:0]  cnt;
  logic [BUS_W-1:0]  data_reg, value_reg;
  logic [3:0]        bytesel_reg;
  logic              fill_reg, desc_reg;
  logic              load, wr_fire;

  // Adding all-ones is a modulo-2^ADDR_W decrement, so both directions share one adder.
  assign step = desc_reg ? {ADDR_W{1'b1}} : ADDR_W'(1);

  always_comb begin
    state_nx      = state;
    bus_req       = 1'b0;
    bus_addr      = addr_hold;
    bus_wrdata    = '0;
    bus_wrbytesel = '0;
    bus_write     = 1'b0;
    busy          = (state != S_IDLE);
    done          = 1'b0;
    load          = 1'b0;
    wr_fire       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (cfg_len == '0) begin
            state_nx = S_DONE;
          end else begin
            load     = 1'b1;
            state_nx = cfg_fill ? S_WR_ISSUE : S_RD_ISSUE;
          end
        end
      end

      S_RD_ISSUE: begin
        bus_req  = 1'b1;
        bus_addr = src_ptr;
        if (abort)          state_nx = S_IDLE;
        else if (bus_grant) state_nx = S_RD_CAPTURE;
      end

      S_RD_CAPTURE: begin
        state_nx = abort ? S_IDLE : S_WR_ISSUE;
      end

      S_WR_ISSUE: begin
        bus_req       = 1'b1;
        bus_addr      = dst_ptr;
        bus_wrdata    = fill_reg ? value_reg : data_reg;
        bus_wrbytesel = bytesel_reg;
        // Strobe is gated by grant and abort combinationally so no stray write can slip out.
        bus_write     = bus_grant && !abort;
        wr_fire       = bus_write;
        if (abort) begin
          state_nx = S_IDLE;
        end else if (wr_fire) begin
          if (cnt == LEN_W'(1)) state_nx = S_DONE;
          else if (!fill_reg)   state_nx = S_RD_ISSUE;
        end
      end

      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      addr_hold   <= '0;
      cnt         <= '0;
      data_reg    <= '0;
      value_reg   <= '0;
      bytesel_reg <= '0;
      fill_reg    <= 1'b0;
      desc_reg    <= 1'b0;
    end else begin
      state     <= state_nx;
      addr_hold <= bus_addr;
      if (load) begin
        src_ptr     <= cfg_src;
        dst_ptr     <= cfg_dst;
        cnt         <= cfg_len;
        value_reg   <= cfg_value;
        bytesel_reg <= cfg_bytesel;
        fill_reg    <= cfg_fill;
        desc_reg    <= cfg_desc;
      end
      // Read data arrives one clock after the address cycle whether or not we still own the bus.
      if (state == S_RD_CAPTURE) data_reg <= bus_rddata;
      if (wr_fire) begin
        cnt     <= cnt - LEN_W'(1);
        src_ptr <= src_ptr + step;
        dst_ptr <= dst_ptr + step;
      end
    end
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - self-checking bench for ram_copy_engine with RAM slave and reference model
module tb_ram_copy_engine;
  localparam int AW = 15;
  localparam int LW = 16;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    string       name;
    logic [14:0] src;
    logic [14:0] dst;
    int          len;
    bit          fill;
    bit          desc;
    logic [31:0] val;
    logic [3:0]  msk;
    int          glo;
    int          ghi;
    int          abort_cyc;
    int          restart_cyc;
    int          exp_words;
    int          exp_done;
    int          exp_busy;
    int          exp_req;
    int          exp_end;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_src = '0;
  logic [AW-1:0] cfg_dst = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_fill = 1'b0;
  logic          cfg_desc = 1'b0;
  logic [31:0]   cfg_value = '0;
  logic [3:0]    cfg_bytesel = '0;
  logic          bus_req;
  logic          bus_grant = 1'b1;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wrdata;
  logic [3:0]    bus_wrbytesel;
  logic          bus_write;
  logic [31:0]   bus_rddata;
  logic          busy;
  logic          done;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic          bd_we = 1'b0;
  logic          bd_clear = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  int errors = 0;
  int checks = 0;
  int res_done, res_dones, res_busy, res_req, res_end, res_writes, res_nogrant, res_timeout;

  ram_copy_engine dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_fill(cfg_fill),
    .cfg_desc(cfg_desc), .cfg_value(cfg_value), .cfg_bytesel(cfg_bytesel),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_wrbytesel(bus_wrbytesel), .bus_write(bus_write), .bus_rddata(bus_rddata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM slave: byte-masked writes, read data registered one clock after the address cycle.
  always @(posedge clk) begin
    if (bd_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus_write) begin
      for (int b = 0; b < 4; b++)
        if (bus_wrbytesel[b]) mem[bus_addr][8*b +: 8] <= bus_wrdata[8*b +: 8];
    end
    bus_rddata <= mem[bus_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic bd_write(input logic [14:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Reference: word i goes from src+/-i to dst+/-i in order, masked by the byte enables.
  task automatic apply_ref(input vec_t v);
    logic [14:0] s, d;
    logic [31:0] w;
    for (int i = 0; i < v.exp_words; i++) begin
      s = v.desc ? v.src - 15'(i) : v.src + 15'(i);
      d = v.desc ? v.dst - 15'(i) : v.dst + 15'(i);
      w = v.fill ? v.val : ref_mem[s];
      for (int b = 0; b < 4; b++)
        if (v.msk[b]) ref_mem[d][8*b +: 8] = w[8*b +: 8];
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, "_mem_bad_words"}, bad, 0);
  endtask

  task automatic run_xfer(input vec_t v, input bit rand_grant);
    res_done = -1; res_dones = 0; res_busy = 0; res_req = 0; res_end = -1;
    res_writes = 0; res_nogrant = 0; res_timeout = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == v.restart_cyc);
      if (cyc == 0) begin
        cfg_src = v.src; cfg_dst = v.dst; cfg_len = LW'(v.len); cfg_fill = v.fill;
        cfg_desc = v.desc; cfg_value = v.val; cfg_bytesel = v.msk;
      end else if (cyc == v.restart_cyc) begin
        cfg_src = v.src ^ 15'h4000; cfg_dst = v.dst ^ 15'h4000; cfg_len = LW'(v.len + 2);
        cfg_fill = ~v.fill; cfg_value = ~v.val; cfg_bytesel = ~v.msk;
      end
      abort = (cyc == v.abort_cyc);
      if (cyc >= v.glo && cyc <= v.ghi) bus_grant = 1'b0;
      else if (rand_grant)              bus_grant = ($urandom_range(0, 3) != 0);
      else                              bus_grant = 1'b1;
      #1;
      if (bus_write) res_writes++;
      if (bus_write && !bus_grant) res_nogrant++;
      if (busy) res_busy++;
      if (bus_req) res_req++;
      if (done) begin res_dones++; res_done = cyc; end
      if (cyc > 0 && !busy) begin
        res_end = cyc;
        break;
      end
    end
    if (res_end < 0) res_timeout = 1;
    start = 1'b0; abort = 1'b0; bus_grant = 1'b1;
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    vecs[0] = '{"copy_asc", 15'h0100, 15'h0200, 4, 0, 0, 32'h0, 4'hF, -1, -1, -1, -1, 4, 13, 13, 8, 14};
    vecs[1] = '{"fill_wrap", 15'h0, 15'h7FFE, 3, 1, 0, 32'hDEADBEEF, 4'b0011, -1, -1, -1, -1, 3, 4, 4, 3, 5};
    vecs[2] = '{"grant_stall", 15'h0100, 15'h0300, 2, 0, 0, 32'h0, 4'hF, 3, 7, -1, -1, 2, 12, 12, 9, 13};
    vecs[3] = '{"desc_overlap", 15'h0013, 15'h0014, 4, 0, 1, 32'h0, 4'hF, -1, -1, -1, -1, 4, 13, 13, 8, 14};
    vecs[4] = '{"abort_fill", 15'h0, 15'h1000, 100, 1, 0, 32'h12345678, 4'hF, -1, -1, 10, -1, 9, -1, 10, 10, 11};
    vecs[5] = '{"zero_len", 15'h0500, 15'h0600, 0, 0, 0, 32'h0, 4'hF, -1, -1, -1, -1, 0, 1, 1, 0, 2};
    vecs[6] = '{"start_busy", 15'h0, 15'h2000, 5, 1, 0, 32'hCAFEF00D, 4'hF, -1, -1, -1, 2, 5, 6, 6, 5, 7};
    vecs[7] = '{"start_abort", 15'h0, 15'h3000, 5, 1, 0, 32'h55AA55AA, 4'hF, -1, -1, 0, -1, 0, -1, 0, 0, 1};

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(negedge clk);
    bd_clear = 1'b1;
    @(negedge clk);
    bd_clear = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_write", bus_write, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wrdata", bus_wrdata, 0);
    chk("rst_bus_wrbytesel", bus_wrbytesel, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) bd_write(15'h0100 + 15'(i), 32'hA0A0A000 + 32'(i));
    for (int i = 0; i < 4; i++) bd_write(15'h0010 + 15'(i), 32'(i + 1));

    for (int k = 0; k < 8; k++) begin
      run_xfer(vecs[k], 1'b0);
      apply_ref(vecs[k]);
      chk({vecs[k].name, "_timeout"}, res_timeout, 0);
      chk({vecs[k].name, "_done_cycle"}, res_done, vecs[k].exp_done);
      chk({vecs[k].name, "_done_pulses"}, res_dones, (vecs[k].exp_done < 0) ? 0 : 1);
      chk({vecs[k].name, "_busy_cycles"}, res_busy, vecs[k].exp_busy);
      chk({vecs[k].name, "_req_cycles"}, res_req, vecs[k].exp_req);
      chk({vecs[k].name, "_idle_cycle"}, res_end, vecs[k].exp_end);
      chk({vecs[k].name, "_writes"}, res_writes, vecs[k].exp_words);
      chk({vecs[k].name, "_write_no_grant"}, res_nogrant, 0);
      cmp_mem(vecs[k].name);
    end

    for (int i = 0; i < 4; i++) chk("copy_asc_word", mem[15'h0200 + 15'(i)], 32'hA0A0A000 + 32'(i));
    chk("fill_7ffe", mem[15'h7FFE], 32'h0000BEEF);
    chk("fill_7fff", mem[15'h7FFF], 32'h0000BEEF);
    chk("fill_wrap_0", mem[0], 32'h0000BEEF);
    chk("stall_word0", mem[15'h0300], 32'hA0A0A000);
    chk("stall_word1", mem[15'h0301], 32'hA0A0A001);
    for (int i = 0; i < 4; i++) chk("desc_word", mem[15'h0011 + 15'(i)], 32'(i + 1));
    chk("abort_last_written", mem[15'h1008], 32'h12345678);
    chk("abort_not_written", mem[15'h1009], 32'h0);
    chk("restart_ignored", mem[15'h6000], 32'h0);

    for (int r = 0; r < 10; r++) begin
      rv = '{"rand", 15'($urandom_range(0, DEPTH - 1)), 15'($urandom_range(0, DEPTH - 1)),
             int'($urandom_range(1, 24)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             $urandom, 4'($urandom_range(0, 15)), -1, -1, -1, -1, 0, -1, -1, -1, -1};
      rv.exp_words = rv.len;
      for (int i = 0; i < rv.len; i++)
        bd_write(rv.desc ? rv.src - 15'(i) : rv.src + 15'(i), $urandom);
      run_xfer(rv, 1'b1);
      apply_ref(rv);
      chk("rand_timeout", res_timeout, 0);
      chk("rand_done_pulses", res_dones, 1);
      chk("rand_writes", res_writes, rv.len);
      chk("rand_write_no_grant", res_nogrant, 0);
      cmp_mem("rand");
    end

    @(negedge clk);
    start = 1'b1; cfg_fill = 1'b1; cfg_desc = 1'b0; cfg_dst = 15'h4000; cfg_len = 16'd50;
    cfg_value = 32'h01020304; cfg_bytesel = 4'hF; bus_grant = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_write", bus_write, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_write", bus_write, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_req", bus_req, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
